// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel between the IF stage and instruction memory.
// The master side (fetch stage) raises imem_req_o with imem_addr_o; the slave
// side (memory) answers with imem_ready_i / imem_data_i, possibly in the same
// cycle as the request.
interface if_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready channel and
// drives the IF/ID register. A one-entry skid buffer holds an instruction
// accepted during a hazard stall; a drain state swallows the reply of a
// request that was still outstanding when a branch redirect arrived.
// Optional feature macro: IF_PERF_CNT_EN adds saturating bubble/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IF_stall_i,
    input  logic        pc_src_i,
    input  logic [31:0] branch_target_i,
    if_stage_if.master  imem,
    output logic        ID_valid_o,
    output logic [31:0] ID_instr_o,
    output logic [31:0] ID_pc_plus4_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] bubble_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding at pc_q
        ST_BUF   = 2'd1,   // instruction parked in skid, IF/ID stalled
        ST_DRAIN = 2'd2    // stale request outstanding, its data is dropped
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic [31:0] skid_q;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_plus4_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] target_d;
    logic        ready;
    logic [31:0] data;

    assign ready      = imem.imem_ready_i;
    assign data       = imem.imem_data_i;
    // Natural 32-bit overflow gives the required wrap at 32'hFFFF_FFFC.
    assign pc_plus4_d = pc_q + 32'd4;
    // Word-align the redirect target; the low two bits are meaningless.
    assign target_d   = branch_target_i & 32'hFFFF_FFFC;

    // Request is decoded from state; held low while reset is asserted so the
    // first request appears only in the cycle after release.
    always_comb begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = pc_q;
        if (!rst_i && (state_q == ST_FETCH || state_q == ST_DRAIN)) begin
            imem.imem_req_o = 1'b1;
        end
        if (state_q == ST_DRAIN) begin
            imem.imem_addr_o = drain_addr_q;
        end
    end

    // Fetch FSM with PC, skid buffer and IF/ID register; redirect outranks
    // stall, and a stall freezes IF/ID unless a redirect flushes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            drain_addr_q  <= 32'h0;
            skid_q        <= 32'h0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_plus4_q <= 32'h0;
        end else if (pc_src_i) begin
            pc_q          <= target_d;
            skid_q        <= 32'h0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_plus4_q <= 32'h0;
            case (state_q)
                ST_FETCH: begin
                    // A request still open must complete before the new
                    // address may be presented; remember what it was.
                    if (!ready) begin
                        state_q      <= ST_DRAIN;
                        drain_addr_q <= pc_q;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Keep draining the original request; only the PC moves.
                    if (ready) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (ready) begin
                        if (IF_stall_i) begin
                            skid_q  <= data;
                            state_q <= ST_BUF;
                        end else begin
                            id_valid_q    <= 1'b1;
                            id_instr_q    <= data;
                            id_pc_plus4_q <= pc_plus4_d;
                            pc_q          <= pc_plus4_d;
                        end
                    end else if (!IF_stall_i) begin
                        id_valid_q    <= 1'b0;
                        id_instr_q    <= 32'h0;
                        id_pc_plus4_q <= 32'h0;
                    end
                end
                ST_BUF: begin
                    if (!IF_stall_i) begin
                        id_valid_q    <= 1'b1;
                        id_instr_q    <= skid_q;
                        id_pc_plus4_q <= pc_plus4_d;
                        pc_q          <= pc_plus4_d;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (!IF_stall_i) begin
                        id_valid_q    <= 1'b0;
                        id_instr_q    <= 32'h0;
                        id_pc_plus4_q <= 32'h0;
                    end
                    if (ready) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign ID_valid_o    = id_valid_q;
    assign ID_instr_o    = id_instr_q;
    assign ID_pc_plus4_o = id_pc_plus4_q;

`ifdef IF_PERF_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        bubble_evt;

    // A bubble due to memory: FETCH without data, or any unstalled DRAIN cycle;
    // flush bubbles are counted separately.
    assign bubble_evt = !pc_src_i && !IF_stall_i &&
                        ((state_q == ST_FETCH && !ready) || state_q == ST_DRAIN);

    // Saturating event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= 16'h0;
            flush_cnt_q  <= 16'h0;
        end else begin
            if (bubble_evt && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
            if (pc_src_i && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, reset cases and a random run
// checked against a fetch-stream reference model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
`ifdef IF_PERF_CNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_stage_if bus ();

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h0000_0013;
    endfunction

    assign bus.imem_data_i = mem_word(bus.imem_addr_o);

    if_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .IF_stall_i      (stall),
        .pc_src_i        (pc_src),
        .branch_target_i (target),
        .imem            (bus),
        .ID_valid_o      (id_valid),
        .ID_instr_o      (id_instr),
        .ID_pc_plus4_o   (id_pc4)
`ifdef IF_PERF_CNT_EN
        ,
        .bubble_cnt_o    (bubble_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        pc_src;
        logic [31:0] tgt;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                                input logic r, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.pc_src = p; v.tgt = t; v.ready = r;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep;
        return v;
    endfunction

    // Random-run reference state
    logic [31:0] exp_next;
    logic        prev_valid;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc4;
    int          deliveries;
    logic [31:0] exp_instr;

    initial begin
        // Zero-wait stream, 3-cycle wait, stall/skid, redirect with drain,
        // redirect vs stall in BUF, pc wrap, double redirect in DRAIN.
        vt[0]  = mk(0,0,32'h0,       1, 1,32'h100,      1,32'h104);
        vt[1]  = mk(0,0,32'h0,       1, 1,32'h104,      1,32'h108);
        vt[2]  = mk(0,0,32'h0,       1, 1,32'h108,      1,32'h10C);
        vt[3]  = mk(0,0,32'h0,       0, 1,32'h10C,      0,32'h0);
        vt[4]  = mk(0,0,32'h0,       0, 1,32'h10C,      0,32'h0);
        vt[5]  = mk(0,0,32'h0,       0, 1,32'h10C,      0,32'h0);
        vt[6]  = mk(0,0,32'h0,       1, 1,32'h10C,      1,32'h110);
        vt[7]  = mk(1,0,32'h0,       1, 1,32'h110,      1,32'h110);
        vt[8]  = mk(1,0,32'h0,       1, 0,32'h110,      1,32'h110);
        vt[9]  = mk(0,0,32'h0,       0, 0,32'h110,      1,32'h114);
        vt[10] = mk(0,0,32'h0,       1, 1,32'h114,      1,32'h118);
        vt[11] = mk(0,1,32'h203,     0, 1,32'h118,      0,32'h0);
        vt[12] = mk(0,0,32'h0,       0, 1,32'h118,      0,32'h0);
        vt[13] = mk(0,0,32'h0,       1, 1,32'h118,      0,32'h0);
        vt[14] = mk(0,0,32'h0,       1, 1,32'h200,      1,32'h204);
        vt[15] = mk(1,0,32'h0,       1, 1,32'h204,      1,32'h204);
        vt[16] = mk(1,1,32'h300,     1, 0,32'h204,      0,32'h0);
        vt[17] = mk(0,0,32'h0,       1, 1,32'h300,      1,32'h304);
        vt[18] = mk(1,0,32'h0,       0, 1,32'h304,      1,32'h304);
        vt[19] = mk(0,0,32'h0,       0, 1,32'h304,      0,32'h0);
        vt[20] = mk(0,1,32'hFFFF_FFFE,1, 1,32'h304,     0,32'h0);
        vt[21] = mk(0,0,32'h0,       1, 1,32'hFFFF_FFFC,1,32'h0);
        vt[22] = mk(0,0,32'h0,       1, 1,32'h0,        1,32'h4);
        vt[23] = mk(0,1,32'h400,     0, 1,32'h4,        0,32'h0);
        vt[24] = mk(0,1,32'h500,     0, 1,32'h4,        0,32'h0);
        vt[25] = mk(0,0,32'h0,       1, 1,32'h4,        0,32'h0);
        vt[26] = mk(0,0,32'h0,       1, 1,32'h500,      1,32'h504);
        vt[27] = mk(1,1,32'h600,     0, 1,32'h504,      0,32'h0);
        vt[28] = mk(1,0,32'h0,       1, 1,32'h504,      0,32'h0);
        vt[29] = mk(0,0,32'h0,       1, 1,32'h600,      1,32'h604);

        // Reset state
        rst = 1'b1; stall = 1'b0; pc_src = 1'b0; target = 32'h0;
        bus.imem_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", {31'h0, bus.imem_req_o}, 32'h0);
        check("reset_valid", {31'h0, id_valid}, 32'h0);
        check("reset_instr", id_instr, 32'h0);
        check("reset_pc4", id_pc4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_req", {31'h0, bus.imem_req_o}, 32'h1);
        check("release_addr", bus.imem_addr_o, 32'h100);

        // Directed table
        for (int i = 0; i < 30; i++) begin
            stall = vt[i].stall; pc_src = vt[i].pc_src; target = vt[i].tgt;
            bus.imem_ready_i = vt[i].ready;
            #1;
            check($sformatf("vec%0d_req", i), {31'h0, bus.imem_req_o}, {31'h0, vt[i].e_req});
            check($sformatf("vec%0d_addr", i), bus.imem_addr_o, vt[i].e_addr);
            @(posedge clk);
            #1;
            exp_instr = vt[i].e_valid ? mem_word(vt[i].e_pc4 - 32'd4) : 32'h0;
            check($sformatf("vec%0d_valid", i), {31'h0, id_valid}, {31'h0, vt[i].e_valid});
            check($sformatf("vec%0d_instr", i), id_instr, exp_instr);
            check($sformatf("vec%0d_pc4", i), id_pc4, vt[i].e_pc4);
            $display("[TB] vec %0d req=%b addr=%h valid=%b instr=%h pc4=%h",
                     i, vt[i].e_req, vt[i].e_addr, id_valid, id_instr, id_pc4);
            @(negedge clk);
        end

        // Reset in the middle of an outstanding request
        stall = 1'b0; pc_src = 1'b0; bus.imem_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midreset_valid", {31'h0, id_valid}, 32'h0);
        check("midreset_pc4", id_pc4, 32'h0);
        check("midreset_req", {31'h0, bus.imem_req_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_addr", bus.imem_addr_o, 32'h100);

        // Random run against the fetch-stream model
        exp_next = 32'h100; prev_valid = 1'b0; prev_instr = 32'h0; prev_pc4 = 32'h0;
        deliveries = 0;
        for (int c = 0; c < 400; c++) begin
            stall  = ($urandom % 4) == 0;
            pc_src = ($urandom % 16) == 0;
            target = $urandom;
            bus.imem_ready_i = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
            if (pc_src) begin
                check("rand_flush", {id_valid, id_instr[30:0]} | id_pc4, 32'h0);
                exp_next = target & 32'hFFFF_FFFC;
            end else if (stall) begin
                check("rand_hold", {id_valid ^ prev_valid, 31'h0} | (id_instr ^ prev_instr)
                      | (id_pc4 ^ prev_pc4), 32'h0);
            end else if (id_valid) begin
                check("rand_instr", id_instr, mem_word(exp_next));
                check("rand_pc4", id_pc4, exp_next + 32'd4);
                $display("[TB] fetch pc=%h instr=%h", exp_next, id_instr);
                exp_next = exp_next + 32'd4;
                deliveries++;
            end else begin
                check("rand_bubble", id_instr | id_pc4, 32'h0);
            end
            prev_valid = id_valid; prev_instr = id_instr; prev_pc4 = id_pc4;
            @(negedge clk);
        end
        check("rand_progress", {31'h0, deliveries >= 40}, 32'h1);

`ifdef IF_PERF_CNT_EN
        // Counters: flushes, saturation, reset
        stall = 1'b0; pc_src = 1'b0; bus.imem_ready_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc_src = 1'b1; target = 32'h800;
        repeat (3) @(posedge clk);
        #1;
        pc_src = 1'b0;
        check("flush_cnt", {16'h0, flush_cnt}, 32'h3);
        check("bubble_cnt_zero", {16'h0, bubble_cnt}, 32'h0);
        bus.imem_ready_i = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("bubble_cnt_sat", {16'h0, bubble_cnt}, 32'hFFFF);
        rst = 1'b1;
        #1;
        check("bubble_cnt_reset", {16'h0, bubble_cnt}, 32'h0);
        check("flush_cnt_reset", {16'h0, flush_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
